symbol_sync_controller: RTL and testbench

- Sequences symbol-timing acquisition and tracking for the 1 Mbps DSSS receiver.
- Sits downstream of the per-symbol peak finder. It consumes the running bin index and the per-symbol max-bin result, decides when timing is locked, tracks small drifts, and declares loss of lock.
- Produces a one-cycle symbol strobe at the locked bin, which the DBPSK demodulator uses to sample despread outputs.

---
 rtl/symbol_sync_controller.sv | 123 ++++++++++++
 tb/tb_symbol_sync_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/symbol_sync_controller.sv
// Symbol-timing acquisition/tracking controller: locks onto a stable per-symbol
// peak bin, tracks small drifts, declares loss of lock and emits a symbol strobe.
module symbol_sync_controller #(
  parameter int BINS_PER_SYMBOL = 20,
  parameter int ACQ_COUNT       = 4,
  parameter int LOSS_COUNT      = 3,
  parameter int TOL             = 1,
  parameter int IDX_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [IDX_W-1:0] bin_index,
  input  logic             bin_valid,
  input  logic [IDX_W-1:0] max_bin_index,
  input  logic             max_index_valid,
  output logic             locked,
  output logic [IDX_W-1:0] timing_index,
  output logic             symbol_strobe,
  output logic             lock_lost,
  output logic [1:0]       sync_state
);

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_ACQUIRE = 2'b01;
  localparam logic [1:0] S_LOCKED  = 2'b10;

  localparam int CNT_MAX = (ACQ_COUNT > LOSS_COUNT) ? ACQ_COUNT : LOSS_COUNT;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  // Handshake: max_bin_index is sampled only in cycles where max_index_valid
  // is high (one-cycle qualifier, no backpressure); bin_index likewise with
  // bin_valid. Neither qualifier gates the other.

  logic [IDX_W-1:0] candidate;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic             peak_in_range;
  logic             acq_consistent;
  logic             trk_consistent;
  logic [CNT_W-1:0] match_next;
  logic [CNT_W-1:0] miss_next;

  // Circular distance check; any out-of-window index is never consistent.
  function automatic logic consistent(input logic [IDX_W-1:0] a,
                                      input logic [IDX_W-1:0] b);
    logic [IDX_W-1:0] d;
    d = (a > b) ? (a - b) : (b - a);
    if (d > IDX_W'(BINS_PER_SYMBOL / 2)) d = IDX_W'(BINS_PER_SYMBOL) - d;
    return (a < IDX_W'(BINS_PER_SYMBOL)) && (b < IDX_W'(BINS_PER_SYMBOL)) &&
           (d <= IDX_W'(TOL));
  endfunction

  always_comb begin
    peak_in_range  = max_bin_index < IDX_W'(BINS_PER_SYMBOL);
    acq_consistent = consistent(max_bin_index, candidate);
    trk_consistent = consistent(max_bin_index, timing_index);
    if (match_cnt == '0 || !acq_consistent) match_next = CNT_W'(1);
    else if (match_cnt >= CNT_W'(ACQ_COUNT)) match_next = CNT_W'(ACQ_COUNT);
    else match_next = match_cnt + CNT_W'(1);
    miss_next = (miss_cnt >= CNT_W'(LOSS_COUNT)) ? CNT_W'(LOSS_COUNT)
                                                 : miss_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      sync_state    <= S_IDLE;
      locked        <= 1'b0;
      timing_index  <= '0;
      symbol_strobe <= 1'b0;
      lock_lost     <= 1'b0;
      candidate     <= '0;
      match_cnt     <= '0;
      miss_cnt      <= '0;
    end else begin
      lock_lost <= 1'b0;
      // Compares against the pre-update timing_index when a peak coincides.
      symbol_strobe <= (sync_state == S_LOCKED) && bin_valid &&
                       (bin_index == timing_index);
      case (sync_state)
        S_IDLE: begin
          sync_state <= S_ACQUIRE;
          match_cnt  <= '0;
        end
        S_ACQUIRE: begin
          if (max_index_valid) begin
            if (!peak_in_range) begin
              match_cnt <= '0;
            end else begin
              candidate <= max_bin_index;
              match_cnt <= match_next;
              if (match_next == CNT_W'(ACQ_COUNT)) begin
                sync_state   <= S_LOCKED;
                timing_index <= max_bin_index;
                locked       <= 1'b1;
                miss_cnt     <= '0;
              end
            end
          end
        end
        S_LOCKED: begin
          if (max_index_valid) begin
            if (trk_consistent) begin
              timing_index <= max_bin_index;
              miss_cnt     <= '0;
            end else begin
              miss_cnt <= miss_next;
              // The triggering peak is dropped rather than seeding a candidate.
              if (miss_next == CNT_W'(LOSS_COUNT)) begin
                sync_state <= S_ACQUIRE;
                locked     <= 1'b0;
                lock_lost  <= 1'b1;
                match_cnt  <= '0;
              end
            end
          end
        end
        default: sync_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_symbol_sync_controller.sv
// Directed, table-driven bench for symbol_sync_controller with hand-written
// sequences for strobe sweep, wrap tracking and miss recovery.
module tb_symbol_sync_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] bin_index;
  logic        bin_valid;
  logic [15:0] max_bin_index;
  logic        max_index_valid;
  logic        locked;
  logic [15:0] timing_index;
  logic        symbol_strobe;
  logic        lock_lost;
  logic [1:0]  sync_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  symbol_sync_controller dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .bin_index       (bin_index),
    .bin_valid       (bin_valid),
    .max_bin_index   (max_bin_index),
    .max_index_valid (max_index_valid),
    .locked          (locked),
    .timing_index    (timing_index),
    .symbol_strobe   (symbol_strobe),
    .lock_lost       (lock_lost),
    .sync_state      (sync_state)
  );

  typedef struct packed {
    logic        en;
    logic        rst;
    logic        mv;
    logic [15:0] mb;
    logic        bv;
    logic [15:0] bi;
    logic        e_lk;
    logic [1:0]  e_st;
    logic [15:0] e_ti;
    logic        e_sb;
    logic        e_ll;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic rst, input logic mv,
                     input int mb, input logic bv, input int bi,
                     input logic e_lk, input logic [1:0] e_st, input int e_ti,
                     input logic e_sb, input logic e_ll);
    vecs.push_back({en, rst, mv, 16'(mb), bv, 16'(bi), e_lk, e_st, 16'(e_ti),
                    e_sb, e_ll});
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample outputs 1 ns after the edge.
  task automatic step(input logic en, input logic rst, input logic mv,
                      input int mb, input logic bv, input int bi);
    enable          = en;
    reset           = rst;
    max_index_valid = mv;
    max_bin_index   = 16'(mb);
    bin_valid       = bv;
    bin_index       = 16'(bi);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic e_lk,
                         input logic [1:0] e_st, input int e_ti,
                         input logic e_sb, input logic e_ll);
    chk({tag, " locked"}, 32'(locked), 32'(e_lk));
    chk({tag, " state"}, 32'(sync_state), 32'(e_st));
    chk({tag, " timing"}, 32'(timing_index), 32'(e_ti));
    chk({tag, " strobe"}, 32'(symbol_strobe), 32'(e_sb));
    chk({tag, " lost"}, 32'(lock_lost), 32'(e_ll));
  endtask

  initial begin
    int strobes;
    // en rst mv mb bv bi | locked state timing strobe lost
    add(0, 1, 0,  0, 0, 0,  0, 2'b00,  0, 0, 0);   // reset
    add(0, 0, 0,  0, 0, 0,  0, 2'b00,  0, 0, 0);
    add(0, 0, 1,  7, 0, 0,  0, 2'b00,  0, 0, 0);   // peak ignored in IDLE
    add(1, 0, 0,  0, 0, 0,  0, 2'b01,  0, 0, 0);
    add(1, 0, 1,  7, 0, 0,  0, 2'b01,  0, 0, 0);   // acquisition 7,7,8,7
    add(1, 0, 1,  7, 0, 0,  0, 2'b01,  0, 0, 0);
    add(1, 0, 1,  8, 0, 0,  0, 2'b01,  0, 0, 0);
    add(1, 0, 1,  7, 1, 7,  1, 2'b10,  7, 0, 0);   // lock cycle: no strobe
    add(1, 0, 0,  0, 1, 7,  1, 2'b10,  7, 1, 0);
    add(1, 0, 0,  0, 0, 0,  1, 2'b10,  7, 0, 0);
    add(1, 0, 1,  3, 0, 0,  1, 2'b10,  7, 0, 0);   // miss 1
    add(1, 0, 1, 15, 0, 0,  1, 2'b10,  7, 0, 0);   // miss 2
    add(1, 0, 1,  8, 0, 0,  1, 2'b10,  8, 0, 0);   // track, misses clear
    add(1, 0, 1,  3, 0, 0,  1, 2'b10,  8, 0, 0);
    add(1, 0, 1, 15, 0, 0,  1, 2'b10,  8, 0, 0);
    add(1, 0, 1,  4, 0, 0,  0, 2'b01,  8, 0, 1);   // loss of lock
    add(1, 0, 0,  0, 0, 0,  0, 2'b01,  8, 0, 0);
    add(1, 0, 1,  5, 0, 0,  0, 2'b01,  8, 0, 0);   // restart 5,5,12x4
    add(1, 0, 1,  5, 0, 0,  0, 2'b01,  8, 0, 0);
    add(1, 0, 1, 12, 0, 0,  0, 2'b01,  8, 0, 0);
    add(1, 0, 1, 12, 0, 0,  0, 2'b01,  8, 0, 0);
    add(1, 0, 1, 12, 0, 0,  0, 2'b01,  8, 0, 0);
    add(1, 0, 1, 12, 0, 0,  1, 2'b10, 12, 0, 0);
    add(0, 0, 0,  0, 0, 0,  0, 2'b00,  0, 0, 0);   // enable drop: no lost
    add(1, 0, 0,  0, 0, 0,  0, 2'b01,  0, 0, 0);
    add(1, 0, 1,  4, 0, 0,  0, 2'b01,  0, 0, 0);
    add(1, 0, 1,  4, 0, 0,  0, 2'b01,  0, 0, 0);
    add(1, 0, 1,  4, 0, 0,  0, 2'b01,  0, 0, 0);
    add(1, 0, 1, 25, 0, 0,  0, 2'b01,  0, 0, 0);   // out of range clears
    add(1, 0, 1,  4, 0, 0,  0, 2'b01,  0, 0, 0);
    add(1, 0, 1,  4, 0, 0,  0, 2'b01,  0, 0, 0);
    add(1, 0, 1,  4, 0, 0,  0, 2'b01,  0, 0, 0);
    add(1, 0, 1,  4, 0, 0,  1, 2'b10,  4, 0, 0);
    add(1, 0, 1,  5, 1, 4,  1, 2'b10,  5, 1, 0);   // pre-update compare
    add(1, 0, 0,  0, 1, 4,  1, 2'b10,  5, 0, 0);
    add(0, 0, 0,  0, 0, 0,  0, 2'b00,  0, 0, 0);
    add(1, 0, 0,  0, 0, 0,  0, 2'b01,  0, 0, 0);
    add(1, 0, 1,  9, 0, 0,  0, 2'b01,  0, 0, 0);
    add(1, 0, 1,  9, 0, 0,  0, 2'b01,  0, 0, 0);
    add(1, 1, 1,  9, 0, 0,  0, 2'b00,  0, 0, 0);   // reset mid-acquire
    add(1, 0, 0,  0, 0, 0,  0, 2'b01,  0, 0, 0);
    add(1, 0, 1,  9, 0, 0,  0, 2'b01,  0, 0, 0);
    add(1, 0, 1,  9, 0, 0,  0, 2'b01,  0, 0, 0);
    add(1, 0, 1,  9, 0, 0,  0, 2'b01,  0, 0, 0);
    add(1, 0, 1,  9, 0, 0,  1, 2'b10,  9, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].rst, vecs[i].mv, int'(vecs[i].mb),
           vecs[i].bv, int'(vecs[i].bi));
      chk_all($sformatf("vec%0d", i), vecs[i].e_lk, vecs[i].e_st,
              int'(vecs[i].e_ti), vecs[i].e_sb, vecs[i].e_ll);
    end

    // Lock at 19, sweep a full window, then track across the wrap.
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 19, 0, 0);
    chk_all("lock19", 1, 2'b10, 19, 0, 0);
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0, 1, i);
      if (symbol_strobe) strobes++;
      chk($sformatf("sweep%0d strobe", i), 32'(symbol_strobe), 32'(i == 19));
    end
    step(1, 0, 0, 0, 0, 0);
    chk("sweep tail strobe", 32'(symbol_strobe), 32'(0));
    chk("sweep strobe count", 32'(strobes), 32'(1));
    step(1, 0, 1, 0, 0, 0);
    chk_all("wrap19to0", 1, 2'b10, 0, 0, 0);
    step(1, 0, 1, 5, 0, 0);
    step(1, 0, 1, 5, 0, 0);
    chk_all("wrap misses", 1, 2'b10, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    chk_all("wrap retrack", 1, 2'b10, 1, 0, 0);

    // Miss recovery: 3,3,10,3,3 keeps lock; a further 3 loses it.
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 10, 0, 0);
    chk_all("lock10", 1, 2'b10, 10, 0, 0);
    step(1, 0, 1, 3, 0, 0);
    chk_all("rec a", 1, 2'b10, 10, 0, 0);
    step(1, 0, 1, 3, 0, 0);
    chk_all("rec b", 1, 2'b10, 10, 0, 0);
    step(1, 0, 1, 10, 0, 0);
    chk_all("rec c", 1, 2'b10, 10, 0, 0);
    step(1, 0, 1, 3, 0, 0);
    chk_all("rec d", 1, 2'b10, 10, 0, 0);
    step(1, 0, 1, 3, 0, 0);
    chk_all("rec e", 1, 2'b10, 10, 0, 0);
    step(1, 0, 1, 3, 0, 0);
    chk_all("rec loss", 0, 2'b01, 10, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    chk_all("rec after", 0, 2'b01, 10, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
